// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the single-bus datapath.
// master: sequencer (drives strobes, reads IR/stop); slave: datapath side.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        stop;
    logic        run;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        PCout, IncPC, MARin, MDRin, MDRout, read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic [7:0]  ALU_control;

    modport master (
        input  IR, stop,
        output run, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output PCout, IncPC, MARin, MDRin, MDRout, read, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
        output ALU_control
    );

    modport slave (
        output IR, stop,
        input  run, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  PCout, IncPC, MARin, MDRin, MDRout, read, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
        input  ALU_control
    );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired fetch/execute control unit for the single-bus datapath.
// Ports: clock, clear (async active-low), bus (IR/stop in, strobes out).
module control_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       unused_ir;
    logic       is_alu, is_addi, is_ld, is_st, is_muldiv;
    logic       is_mfhi, is_mflo, is_halt, is_long;

    assign opcode    = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    // add..shl occupy the contiguous opcode range 00011..01000
    assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_addi   = (opcode == OP_ADDI);
    assign is_ld     = (opcode == OP_LD);
    assign is_st     = (opcode == OP_ST);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_mfhi   = (opcode == OP_MFHI);
    assign is_mflo   = (opcode == OP_MFLO);
    assign is_halt   = (opcode == OP_HALT);
    assign is_long   = is_alu | is_addi | is_ld | is_st | is_muldiv;

    // stop is only consulted on an instruction's final step
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= T0;
        end else begin
            unique case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: state <= T3;
                T3: begin
                    if (is_halt)      state <= HALT;
                    else if (is_long) state <= T4;
                    else              state <= bus.stop ? PAUSE : T0;
                end
                T4: state <= T5;
                T5: begin
                    if (is_ld || is_st) state <= T6;
                    else                state <= bus.stop ? PAUSE : T0;
                end
                T6: begin
                    if (is_st) state <= bus.stop ? PAUSE : T0;
                    else       state <= T7;
                end
                T7:    state <= bus.stop ? PAUSE : T0;
                PAUSE: state <= bus.stop ? PAUSE : T0;
                HALT:  state <= HALT;
                default: state <= T0;
            endcase
        end
    end

    // Outputs are gated by clear so reset silences every strobe at once
    always_comb begin
        bus.run         = 1'b0;
        bus.Gra         = 1'b0;
        bus.Grb         = 1'b0;
        bus.Grc         = 1'b0;
        bus.Rin         = 1'b0;
        bus.Rout        = 1'b0;
        bus.BAout       = 1'b0;
        bus.Cout        = 1'b0;
        bus.PCout       = 1'b0;
        bus.IncPC       = 1'b0;
        bus.MARin       = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.read        = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zin         = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.Zhighout    = 1'b0;
        bus.HIin        = 1'b0;
        bus.LOin        = 1'b0;
        bus.HIout       = 1'b0;
        bus.LOout       = 1'b0;
        bus.ALU_control = 8'h00;
        if (clear) begin
            bus.run = (state != PAUSE) && (state != HALT);
            case (state)
                T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                end
                T1: begin
                    bus.read  = 1'b1;
                    bus.MDRin = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                T3: begin
                    unique case (1'b1)
                        is_alu, is_addi: begin
                            bus.Grb  = 1'b1;
                            bus.Rout = 1'b1;
                            bus.Yin  = 1'b1;
                        end
                        is_ld, is_st: begin
                            bus.Grb   = 1'b1;
                            bus.BAout = 1'b1;
                            bus.Yin   = 1'b1;
                        end
                        is_muldiv: begin
                            bus.Gra  = 1'b1;
                            bus.Rout = 1'b1;
                            bus.Yin  = 1'b1;
                        end
                        is_mfhi: begin
                            bus.HIout = 1'b1;
                            bus.Gra   = 1'b1;
                            bus.Rin   = 1'b1;
                        end
                        is_mflo: begin
                            bus.LOout = 1'b1;
                            bus.Gra   = 1'b1;
                            bus.Rin   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    bus.Zin = 1'b1;
                    if (is_alu) begin
                        bus.Grc         = 1'b1;
                        bus.Rout        = 1'b1;
                        bus.ALU_control = {3'b000, opcode};
                    end else if (is_muldiv) begin
                        bus.Grb         = 1'b1;
                        bus.Rout        = 1'b1;
                        bus.ALU_control = {3'b000, opcode};
                    end else begin
                        // addi/ld/st: base + constant uses the add op
                        bus.Cout        = 1'b1;
                        bus.ALU_control = 8'h03;
                    end
                end
                T5: begin
                    if (is_muldiv) begin
                        bus.HIin = 1'b1;
                        bus.LOin = 1'b1;
                    end else if (is_ld || is_st) begin
                        bus.Zlowout = 1'b1;
                        bus.MARin   = 1'b1;
                    end else begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                    end
                end
                T6: begin
                    if (is_st) begin
                        bus.Gra   = 1'b1;
                        bus.Rout  = 1'b1;
                        bus.MDRin = 1'b1;
                    end else begin
                        bus.read  = 1'b1;
                        bus.MDRin = 1'b1;
                    end
                end
                T7: begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction strobe
// sequences from a step-table model, random opcodes/stop, reset and halt.
module tb_control_sequencer;
    localparam logic [21:0] GRA    = 22'h000001;
    localparam logic [21:0] GRB    = 22'h000002;
    localparam logic [21:0] GRC    = 22'h000004;
    localparam logic [21:0] RIN    = 22'h000008;
    localparam logic [21:0] ROUT   = 22'h000010;
    localparam logic [21:0] BAOUT  = 22'h000020;
    localparam logic [21:0] COUT   = 22'h000040;
    localparam logic [21:0] PCOUT  = 22'h000080;
    localparam logic [21:0] INCPC  = 22'h000100;
    localparam logic [21:0] MARIN  = 22'h000200;
    localparam logic [21:0] MDRIN  = 22'h000400;
    localparam logic [21:0] MDROUT = 22'h000800;
    localparam logic [21:0] READ   = 22'h001000;
    localparam logic [21:0] IRIN   = 22'h002000;
    localparam logic [21:0] YIN    = 22'h004000;
    localparam logic [21:0] ZIN    = 22'h008000;
    localparam logic [21:0] ZLO    = 22'h010000;
    localparam logic [21:0] HIIN   = 22'h040000;
    localparam logic [21:0] LOIN   = 22'h080000;
    localparam logic [21:0] HIOUT  = 22'h100000;
    localparam logic [21:0] LOOUT  = 22'h200000;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   failures = 0;
    logic [30:0] exp_q[$];

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    wire [30:0] obs = {bus.run, bus.ALU_control,
                       bus.LOout, bus.HIout, bus.LOin, bus.HIin,
                       bus.Zhighout, bus.Zlowout, bus.Zin, bus.Yin,
                       bus.IRin, bus.read, bus.MDRout, bus.MDRin,
                       bus.MARin, bus.IncPC, bus.PCout, bus.Cout,
                       bus.BAout, bus.Rout, bus.Rin, bus.Grc,
                       bus.Grb, bus.Gra};

    function automatic logic [30:0] s(input logic [7:0] alu,
                                      input logic [21:0] m);
        return {1'b1, alu, m};
    endfunction

    // Expected step list T0..final for one instruction
    function automatic void build(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(s(8'h00, PCOUT | MARIN | INCPC));
        exp_q.push_back(s(8'h00, READ | MDRIN));
        exp_q.push_back(s(8'h00, MDROUT | IRIN));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                exp_q.push_back(s(8'h00, GRB | ROUT | YIN));
                exp_q.push_back(s({3'b000, op}, GRC | ROUT | ZIN));
                exp_q.push_back(s(8'h00, ZLO | GRA | RIN));
            end
            5'd12: begin
                exp_q.push_back(s(8'h00, GRB | ROUT | YIN));
                exp_q.push_back(s(8'h03, COUT | ZIN));
                exp_q.push_back(s(8'h00, ZLO | GRA | RIN));
            end
            5'd0, 5'd2: begin
                exp_q.push_back(s(8'h00, GRB | BAOUT | YIN));
                exp_q.push_back(s(8'h03, COUT | ZIN));
                exp_q.push_back(s(8'h00, ZLO | MARIN));
                if (op == 5'd0) begin
                    exp_q.push_back(s(8'h00, READ | MDRIN));
                    exp_q.push_back(s(8'h00, MDROUT | GRA | RIN));
                end else begin
                    exp_q.push_back(s(8'h00, GRA | ROUT | MDRIN));
                end
            end
            5'd15, 5'd16: begin
                exp_q.push_back(s(8'h00, GRA | ROUT | YIN));
                exp_q.push_back(s({3'b000, op}, GRB | ROUT | ZIN));
                exp_q.push_back(s(8'h00, HIIN | LOIN));
            end
            5'd24: exp_q.push_back(s(8'h00, HIOUT | GRA | RIN));
            5'd25: exp_q.push_back(s(8'h00, LOOUT | GRA | RIN));
            default: exp_q.push_back(s(8'h00, 22'h0));
        endcase
    endfunction

    task automatic check(input string tag, input logic [30:0] o,
                         input logic [30:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called just after a negedge; leaves state T0 visible until next posedge
    task automatic do_reset(input string tag);
        clear = 1'b0;
        #1 check({tag, "_async"}, obs, 31'h0);
        @(negedge clk);
        #1 check({tag, "_hold"}, obs, 31'h0);
        @(posedge clk);
        #1 clear = 1'b1;
        #1 check({tag, "_release"}, obs, s(8'h00, PCOUT | MARIN | INCPC));
    endtask

    task automatic run_instr(input logic [31:0] ir, input bit stop_final,
                             input int abort_at, input bit hold_stop);
        int n;
        build(ir[31:27]);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) bus.IR = ir;
            #1 check($sformatf("op%02h_T%0d", ir[31:27], i), obs, exp_q[i]);
            if (i == abort_at) begin
                do_reset("abort");
                return;
            end
            if (i == n - 1)               bus.stop = stop_final;
            else if (hold_stop && i >= 2) bus.stop = 1'b1;
            else                          bus.stop = 1'($urandom_range(0, 1));
        end
        if (ir[31:27] == 5'd27) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                bus.stop = 1'($urandom_range(0, 1));
                #1 check("halt_sticky", obs, 31'h0);
            end
        end else if (stop_final) begin
            int p;
            p = $urandom_range(1, 3);
            for (int k = 0; k < p; k++) begin
                @(negedge clk);
                #1 check("pause", obs, 31'h0);
                if (k == p - 1) bus.stop = 1'b0;
            end
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [4:0]  ops [16];
        ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                5'd12, 5'd15, 5'd16, 5'd24, 5'd25, 5'd26, 5'd10, 5'd31};
        clear   = 1'b0;
        bus.stop = 1'b0;
        bus.IR  = 32'h0;
        #3 check("reset_state", obs, 31'h0);
        do_reset("init");

        run_instr(32'h19890000, 1'b0, -1, 1'b0);
        run_instr(32'h01880005, 1'b0, -1, 1'b0);
        run_instr(32'h79100000, 1'b0, -1, 1'b0);
        run_instr(32'h19890000, 1'b1, -1, 1'b1);
        run_instr(32'h50000000, 1'b0, -1, 1'b0);
        run_instr(32'h11000007, 1'b0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'd27) op = 5'd26;
            end else begin
                op = ops[$urandom_range(0, 15)];
            end
            run_instr({op, 27'($urandom)}, ($urandom_range(0, 3) == 0),
                      -1, 1'b0);
        end

        run_instr(32'hD8000000, 1'b0, -1, 1'b0);
        do_reset("halt_rst");
        run_instr(32'h01880005, 1'b0, 6, 1'b0);
        run_instr(32'h19890000, 1'b0, -1, 1'b0);
        run_instr(32'hC8000000, 1'b0, -1, 1'b0);
        @(negedge clk);
        #1 check("final_T0", obs, s(8'h00, PCOUT | MARIN | INCPC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
